// File: rtl/aes_dom_pkg.sv
// Shared constants and FSM encoding for the masked AES byte-serial sequencer.
package aes_dom_pkg;

    localparam int NBYTES = 16;
    localparam int TIMEOUT_CYC_DFLT = 4096;
    localparam logic [3:0] LAST_BYTE = 4'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_CAPT = 3'd3,
        S_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/aes_dom_trg_gen.sv
// Loadable down-counter; pulses for one cycle when the count sits at 1.
module aes_dom_trg_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         pulse_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign pulse_o = (cnt_q == W'(1));

endmodule

// File: rtl/aes_dom_seq.sv
// Command sequencer for the byte-serial masked AES core.
// Optional WAIT watchdog: define AES_SEQ_TIMEOUT_EN.
module aes_dom_seq
    import aes_dom_pkg::*;
#(
    parameter int TRG_W = 8
`ifdef AES_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DFLT
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [127:0]     ptxt_i,
    input  logic [127:0]     key_i,
    input  logic [TRG_W-1:0] trg_delay_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             core_start_o,
    output logic [7:0]       core_pt_o,
    output logic [7:0]       core_key_o,
    input  logic             core_done_i,
    input  logic [7:0]       core_ct_i,
    output logic             trg_o,
    output logic [127:0]     result_o,
    output logic             result_valid_o,
    output logic             timeout_o
);

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic [127:0]   pt_q;
    logic [127:0]   key_q;
    logic [119:0]   cap_q;
    logic [127:0]   cap_d;
    logic [127:0]   res_q;
    logic           rv_q;
    logic           accept;

    assign accept = (state_q == S_IDLE) && start_i;
    assign cap_d  = {cap_q, core_ct_i};

`ifdef AES_SEQ_TIMEOUT_EN
    localparam logic [12:0] WD_LAST = 13'(TIMEOUT_CYC - 1);
    logic [12:0] wd_q;
    logic        to_q;
    logic        wd_hit;

    assign wd_hit    = (wd_q == WD_LAST);
    assign timeout_o = to_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_q <= '0;
        else if (state_q == S_WAIT)
            wd_q <= wd_q + 13'd1;
        else
            wd_q <= '0;
    end
`else
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pt_q    <= '0;
            key_q   <= '0;
            cap_q   <= '0;
            res_q   <= '0;
            rv_q    <= 1'b0;
`ifdef AES_SEQ_TIMEOUT_EN
            to_q    <= 1'b0;
`endif
        end else begin
            rv_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        pt_q    <= ptxt_i;
                        key_q   <= key_i;
                        cnt_q   <= '0;
                        state_q <= S_LOAD;
`ifdef AES_SEQ_TIMEOUT_EN
                        to_q    <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    pt_q  <= {pt_q[119:0], 8'h00};
                    key_q <= {key_q[119:0], 8'h00};
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_BYTE)
                        state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // done has priority over a watchdog expiry in the same cycle
                    if (core_done_i) begin
                        cap_q   <= cap_d[119:0];
                        cnt_q   <= 4'd1;
                        state_q <= S_CAPT;
                    end
`ifdef AES_SEQ_TIMEOUT_EN
                    else if (wd_hit) begin
                        to_q    <= 1'b1;
                        res_q   <= '0;
                        rv_q    <= 1'b1;
                        state_q <= S_FIN;
                    end
`endif
                end
                S_CAPT: begin
                    cap_q <= cap_d[119:0];
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAST_BYTE) begin
                        res_q   <= cap_d;
                        rv_q    <= 1'b1;
                        state_q <= S_FIN;
                    end
                end
                S_FIN:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    aes_dom_trg_gen #(
        .W(TRG_W)
    ) u_trg (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .val_i  (trg_delay_i),
        .pulse_o(trg_o)
    );

    assign ready_o        = (state_q == S_IDLE);
    assign busy_o         = ~ready_o;
    assign core_start_o   = (state_q == S_LOAD) && (cnt_q == 4'd0);
    assign core_pt_o      = (state_q == S_LOAD) ? pt_q[127:120] : 8'h00;
    assign core_key_o     = (state_q == S_LOAD) ? key_q[127:120] : 8'h00;
    assign result_o       = res_q;
    assign result_valid_o = rv_q;

endmodule

// File: tb/tb_aes_dom_seq.sv
// Directed bench for aes_dom_seq with a behavioural byte-serial core model.
module tb_aes_dom_seq;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [127:0] ptxt_i;
    logic [127:0] key_i;
    logic [7:0]   trg_delay_i;
    logic         ready_o;
    logic         busy_o;
    logic         core_start_o;
    logic [7:0]   core_pt_o;
    logic [7:0]   core_key_o;
    logic         core_done_i;
    logic [7:0]   core_ct_i;
    logic         trg_o;
    logic [127:0] result_o;
    logic         result_valid_o;
    logic         timeout_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    aes_dom_seq #(
        .TRG_W(8)
`ifdef AES_SEQ_TIMEOUT_EN
        , .TIMEOUT_CYC(64)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .ptxt_i        (ptxt_i),
        .key_i         (key_i),
        .trg_delay_i   (trg_delay_i),
        .ready_o       (ready_o),
        .busy_o        (busy_o),
        .core_start_o  (core_start_o),
        .core_pt_o     (core_pt_o),
        .core_key_o    (core_key_o),
        .core_done_i   (core_done_i),
        .core_ct_i     (core_ct_i),
        .trg_o         (trg_o),
        .result_o      (result_o),
        .result_valid_o(result_valid_o),
        .timeout_o     (timeout_o)
    );

    // event recorders, cycle index = value of cyc seen at the negedge
    int cyc = 0;
    int acc_q[$];
    int rv_q[$];
    int trg_q[$];
    int cs_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (!rst && ready_o && start_i) acc_q.push_back(cyc);

    always @(negedge clk) begin
        if (result_valid_o) rv_q.push_back(cyc);
        if (trg_o) trg_q.push_back(cyc);
        if (core_start_o) cs_q.push_back(cyc);
    end

    // core model: ct byte 0 arrives lat cycles after the last LOAD byte
    int           mc = -1;
    int           lat = 5;
    bit           never_done = 1'b0;
    bit           spur = 1'b0;
    logic [127:0] m_pt;
    logic [127:0] m_key;
    logic [127:0] m_ct;

    assign m_ct = (m_pt == FIPS_PT && m_key == FIPS_KEY) ? FIPS_CT
                                                         : (m_pt ^ m_key);

    function automatic logic [7:0] ct_byte(input int k);
        logic [127:0] t;
        t = m_ct >> (8 * (15 - k));
        return t[7:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mc          <= -1;
            core_done_i <= 1'b0;
            core_ct_i   <= 8'h00;
        end else begin
            if (core_start_o) begin
                mc    <= 1;
                m_pt  <= {m_pt[119:0], core_pt_o};
                m_key <= {m_key[119:0], core_key_o};
            end else if (mc > 0) begin
                mc <= mc + 1;
                if (mc <= 15) begin
                    m_pt  <= {m_pt[119:0], core_pt_o};
                    m_key <= {m_key[119:0], core_key_o};
                end
            end
            core_done_i <= 1'b0;
            core_ct_i   <= 8'h00;
            if (mc == 2 && spur) begin
                core_done_i <= 1'b1;
                core_ct_i   <= 8'hEE;
            end else if (mc >= 14 + lat && mc <= 29 + lat && !never_done) begin
                core_done_i <= (mc == 14 + lat);
                core_ct_i   <= ct_byte(mc - 14 - lat);
            end
            if (mc == 29 + lat) mc <= -1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [127:0] pt, input logic [127:0] k,
                         input logic [7:0] d);
        int n = 0;
        while (!ready_o && n < 500) begin
            tick();
            n++;
        end
        ptxt_i      = pt;
        key_i       = k;
        trg_delay_i = d;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_rv(input int n0, input int budget);
        int n = 0;
        while (rv_q.size() <= n0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        rst         = 1'b1;
        start_i     = 1'b0;
        ptxt_i      = '0;
        key_i       = '0;
        trg_delay_i = '0;
        repeat (3) tick();
        obs = {ready_o, busy_o, core_start_o, trg_o, result_valid_o,
               timeout_o, core_pt_o, core_key_o};
        total_cnt++;
        if (obs !== 22'h200000)
            $display("FAIL reset_flags got=%h exp=%h", obs, 22'h200000);
        else pass_cnt++;
        total_cnt++;
        if (result_o !== 128'h0)
            $display("FAIL reset_result got=%h exp=0", result_o);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0)
            $display("FAIL reset_ready got=%b%b exp=10", ready_o, busy_o);
        else pass_cnt++;
    endtask

    task automatic test_fips();
        int a0 = acc_q.size();
        int n0 = rv_q.size();
        int t0 = trg_q.size();
        int lt;
        lat = 200;
        issue(FIPS_PT, FIPS_KEY, 8'h05);
        wait_rv(n0, 400);
        total_cnt++;
        if (acc_q.size() !== a0 + 1 || rv_q.size() !== n0 + 1)
            $display("FAIL fips_counts acc=%0d rv=%0d exp=1/1",
                     acc_q.size() - a0, rv_q.size() - n0);
        else pass_cnt++;
        lt = rv_q[$] - acc_q[$];
        total_cnt++;
        if (lt !== 232) $display("FAIL fips_latency got=%0d exp=232", lt);
        else pass_cnt++;
        total_cnt++;
        if (result_o !== FIPS_CT)
            $display("FAIL fips_result got=%h exp=%h", result_o, FIPS_CT);
        else pass_cnt++;
        total_cnt++;
        if (m_pt !== FIPS_PT)
            $display("FAIL fips_pt_stream got=%h exp=%h", m_pt, FIPS_PT);
        else pass_cnt++;
        total_cnt++;
        if (m_key !== FIPS_KEY)
            $display("FAIL fips_key_stream got=%h exp=%h", m_key, FIPS_KEY);
        else pass_cnt++;
        total_cnt++;
        if (cs_q[$] !== acc_q[$] + 1)
            $display("FAIL fips_core_start got=%0d exp=%0d", cs_q[$], acc_q[$] + 1);
        else pass_cnt++;
        total_cnt++;
        if (trg_q.size() !== t0 + 1 || trg_q[$] !== acc_q[$] + 5)
            $display("FAIL trg_delay5 n=%0d at=%0d exp n=1 at=%0d",
                     trg_q.size() - t0, trg_q[$], acc_q[$] + 5);
        else pass_cnt++;
    endtask

    task automatic test_trg_edges();
        int n0 = rv_q.size();
        int t0 = trg_q.size();
        lat = 5;
        issue(128'h0f0e0d0c0b0a09080706050403020100,
              128'hffffffff000000001111111122222222, 8'h00);
        wait_rv(n0, 200);
        total_cnt++;
        if (trg_q.size() !== t0)
            $display("FAIL trg_delay0 pulses=%0d exp=0", trg_q.size() - t0);
        else pass_cnt++;
        total_cnt++;
        if (result_o !== 128'hf0f1f2f30b0a09081617141521202322)
            $display("FAIL trg0_result got=%h exp=%h", result_o,
                     128'hf0f1f2f30b0a09081617141521202322);
        else pass_cnt++;
        total_cnt++;
        if (rv_q[$] - acc_q[$] !== 37)
            $display("FAIL lat5_latency got=%0d exp=37", rv_q[$] - acc_q[$]);
        else pass_cnt++;
        t0 = trg_q.size();
        issue(128'h1, 128'h2, 8'h01);
        wait_rv(n0 + 1, 200);
        total_cnt++;
        if (trg_q.size() !== t0 + 1 || trg_q[$] !== acc_q[$] + 1)
            $display("FAIL trg_delay1 n=%0d at=%0d exp n=1 at=%0d",
                     trg_q.size() - t0, trg_q[$], acc_q[$] + 1);
        else pass_cnt++;
        total_cnt++;
        if (cs_q[$] !== trg_q[$])
            $display("FAIL trg1_vs_start got=%0d exp=%0d", trg_q[$], cs_q[$]);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int a0 = acc_q.size();
        int n0 = rv_q.size();
        int n = 0;
        lat = 5;
        ptxt_i      = 128'hdeadbeef_00000000_cafef00d_12345678;
        key_i       = 128'h0;
        trg_delay_i = 8'h00;
        start_i     = 1'b1;
        while (acc_q.size() < a0 + 2 && n < 200) begin
            tick();
            n++;
        end
        start_i = 1'b0;
        wait_rv(n0 + 1, 200);
        repeat (20) tick();
        total_cnt++;
        if (acc_q.size() !== a0 + 2 || rv_q.size() !== n0 + 2)
            $display("FAIL b2b_counts acc=%0d rv=%0d exp=2/2",
                     acc_q.size() - a0, rv_q.size() - n0);
        else pass_cnt++;
        total_cnt++;
        if (acc_q[a0 + 1] - acc_q[a0] !== 38)
            $display("FAIL b2b_spacing got=%0d exp=38", acc_q[a0 + 1] - acc_q[a0]);
        else pass_cnt++;
        total_cnt++;
        if (acc_q[a0 + 1] !== rv_q[n0] + 1)
            $display("FAIL b2b_ready_gap got=%0d exp=%0d", acc_q[a0 + 1], rv_q[n0] + 1);
        else pass_cnt++;
        total_cnt++;
        if (result_o !== 128'hdeadbeef_00000000_cafef00d_12345678)
            $display("FAIL b2b_result got=%h", result_o);
        else pass_cnt++;
    endtask

    task automatic test_start_during_wait();
        int a0 = acc_q.size();
        int n0 = rv_q.size();
        lat = 40;
        issue(128'haaaa, 128'h5555, 8'h00);
        repeat (20) tick();
        ptxt_i  = 128'h1234;
        key_i   = 128'h0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_rv(n0, 200);
        total_cnt++;
        if (acc_q.size() !== a0 + 1)
            $display("FAIL busy_start_accepts got=%0d exp=1", acc_q.size() - a0);
        else pass_cnt++;
        total_cnt++;
        if (rv_q[$] - acc_q[$] !== 72)
            $display("FAIL busy_start_latency got=%0d exp=72", rv_q[$] - acc_q[$]);
        else pass_cnt++;
        repeat (10) tick();
        total_cnt++;
        if (result_o !== 128'hffff || rv_q.size() !== n0 + 1)
            $display("FAIL busy_start_result got=%h n=%0d exp=ffff n=1",
                     result_o, rv_q.size() - n0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n0 = rv_q.size();
        int tgt;
        int n = 0;
        logic [21:0] obs;
        lat = 10;
        issue(128'h77, 128'h88, 8'h00);
        tgt = acc_q[$] + 16 + 10 + 7;
        while (cyc < tgt && n < 300) begin
            tick();
            n++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs = {ready_o, busy_o, core_start_o, trg_o, result_valid_o,
               timeout_o, core_pt_o, core_key_o};
        total_cnt++;
        if (obs !== 22'h200000)
            $display("FAIL midrst_flags got=%h exp=%h", obs, 22'h200000);
        else pass_cnt++;
        total_cnt++;
        if (result_o !== 128'h0)
            $display("FAIL midrst_result got=%h exp=0", result_o);
        else pass_cnt++;
        repeat (60) tick();
        total_cnt++;
        if (rv_q.size() !== n0)
            $display("FAIL midrst_no_valid got=%0d exp=0", rv_q.size() - n0);
        else pass_cnt++;
        issue(128'h0102, 128'h0300, 8'h00);
        wait_rv(n0, 200);
        total_cnt++;
        if (result_o !== 128'h0202 || rv_q[$] - acc_q[$] !== 42)
            $display("FAIL midrst_next got=%h lat=%0d exp=0202 lat=42",
                     result_o, rv_q[$] - acc_q[$]);
        else pass_cnt++;
    endtask

    task automatic test_spurious();
        int n0 = rv_q.size();
        lat  = 8;
        spur = 1'b1;
        issue(128'hffff0000ffff0000ffff0000ffff0000,
              128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 8'h00);
        wait_rv(n0, 200);
        spur = 1'b0;
        total_cnt++;
        if (result_o !== 128'hf0f00f0ff0f00f0ff0f00f0ff0f00f0f)
            $display("FAIL spurious_result got=%h", result_o);
        else pass_cnt++;
        total_cnt++;
        if (rv_q.size() !== n0 + 1 || rv_q[$] - acc_q[$] !== 40)
            $display("FAIL spurious_latency n=%0d lat=%0d exp n=1 lat=40",
                     rv_q.size() - n0, rv_q[$] - acc_q[$]);
        else pass_cnt++;
    endtask

`ifdef AES_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n0 = rv_q.size();
        lat        = 5;
        never_done = 1'b1;
        issue(128'h99, 128'h66, 8'h00);
        wait_rv(n0, 300);
        never_done = 1'b0;
        total_cnt++;
        if (rv_q.size() !== n0 + 1 || rv_q[$] - acc_q[$] !== 81)
            $display("FAIL timeout_latency n=%0d lat=%0d exp n=1 lat=81",
                     rv_q.size() - n0, rv_q[$] - acc_q[$]);
        else pass_cnt++;
        total_cnt++;
        if (timeout_o !== 1'b1 || result_o !== 128'h0)
            $display("FAIL timeout_flag got=%b/%h exp=1/0", timeout_o, result_o);
        else pass_cnt++;
        issue(128'h99, 128'h66, 8'h00);
        total_cnt++;
        if (timeout_o !== 1'b0)
            $display("FAIL timeout_clear got=%b exp=0", timeout_o);
        else pass_cnt++;
        wait_rv(n0 + 1, 200);
        total_cnt++;
        if (result_o !== 128'hff)
            $display("FAIL timeout_next got=%h exp=ff", result_o);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_fips();
        test_trg_edges();
        test_back_to_back();
        test_start_during_wait();
        test_reset_mid();
        test_spurious();
`ifdef AES_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
